paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameters: STEP_DIV, default 100000, clk cycles per move tick; STEP, default 1, pixels per tick; Y_INIT, default 180, serve bar centre; Y_MIN, default 30, top centre limit; Y_MAX, default 329, bottom centre limit; DEADBAND, default 10, CPU tracking tolerance; SERVE_TICKS, default 120, serve hold ticks; WIN_SCORE, default 7, winning score (1..15).
REQ-002 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-low reset; btn_1_up/btn_1_dn/btn_2_up/btn_2_dn in 1 each, raw buttons; btn_start in 1 raw button; cpu_2 in 1 selects CPU control of bar 2; ball_y in 10 ball centre y; point_1/point_2 in 1 one-cycle score pulses; bar_1_y/bar_2_y out 10 bar centre y; score_1/score_2 out 4; winner out 2 (01 p1, 10 p2, 11 tie); freeze out 1 high outside PLAY.
REQ-003 SHALL use one clock domain (clk); reset is asynchronous, active-low.

Function
REQ-004 SHALL pass every raw button through a 2-flop synchronizer; movement uses synchronized levels, start uses synchronized rising edge (one-cycle pulse).
REQ-005 SHALL run a prescaler 0..STEP_DIV-1 in all states; tick asserted one cycle when count == STEP_DIV-1, then wrap to 0.
REQ-006 SHALL use FSM states SERVE, PLAY, OVER; freeze = 1 in SERVE and OVER.
REQ-007 PLAY, tick, manual bar: up-only -> y - STEP clamped to Y_MIN; down-only -> y + STEP clamped to Y_MAX; both or neither -> hold. y increases downward.
REQ-008 PLAY, tick, cpu_2 = 1: bar_2 ignores btn_2_*; ball_y > bar_2_y + DEADBAND -> +STEP; ball_y + DEADBAND < bar_2_y -> -STEP; else hold; same clamps.
REQ-009 Arithmetic SHALL be done 11-bit unsigned; no underflow/overflow wrap when clamping.
REQ-010 PLAY, point_1 pulse: score_1 + 1; point_2: score_2 + 1; both same cycle: both increment.
REQ-011 After increment, any score == WIN_SCORE -> OVER next cycle, winner set (11 if both); else -> SERVE.
REQ-012 Entry to SERVE SHALL set both bars to Y_INIT and clear a serve counter; each tick increments it; at SERVE_TICKS ticks -> PLAY.
REQ-013 point pulses in SERVE or OVER SHALL be ignored; buttons SHALL not move bars in SERVE or OVER.
REQ-014 OVER holds scores, winner, bars; start pulse -> scores 0, winner 00, bars Y_INIT, -> SERVE.
REQ-015 start pulse outside OVER SHALL be ignored.
REQ-016 Scores SHALL never exceed WIN_SCORE.

Reset
REQ-017 reset low SHALL immediately force: state SERVE, serve counter 0, prescaler 0, bar_1_y = bar_2_y = Y_INIT, scores 0, winner 00, freeze 1, synchronizer flops 0.
REQ-018 Reset asserted mid-move or mid-serve SHALL discard all progress; operation resumes on first clk edge after release.

Structure
REQ-019 Shared package pong_pkg SHALL hold field constants (Y_INIT, Y_MIN, Y_MAX, bar half-height 30) and the SERVE/PLAY/OVER state encoding, shared with the ball and video blocks.
REQ-020 Sub-module btn_sync (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated per button.

Verification (STEP_DIV=4, SERVE_TICKS=2, WIN_SCORE=2)
REQ-021 Reset release, no input -> freeze 1 for 8 cycles, then PLAY, bars 180.
REQ-022 PLAY, btn_1_up held 200 ticks -> bar_1_y decrements 1 per tick, stops at 30; btn_1_dn held -> stops at 329; both held -> no change.
REQ-023 PLAY, cpu_2=1, ball_y=250, bar_2_y=180 -> bar_2_y +1 per tick until 240, then hold; ball_y=185 -> hold.
REQ-024 PLAY, point_2 pulse -> score_2=1, SERVE, bars 180, freeze 1; point_1 during SERVE -> score_1 stays 0.
REQ-025 Scores 1/1, point_1 and point_2 same cycle -> scores 2/2, winner 11, OVER; btn_start press -> scores 0, winner 00, SERVE.
REQ-026 Assert reset during SERVE tick 1 with score_1=1 -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
// Field geometry and game-state encoding shared by the paddle, ball and video blocks.
package pong_pkg;

  localparam int PONG_Y_INIT   = 180;
  localparam int PONG_Y_MIN    = 30;
  localparam int PONG_Y_MAX    = 329;
  localparam int PONG_BAR_HALF = 30;

  typedef enum logic [1:0] {
    ST_SERVE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } game_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw button, with a one-cycle rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic meta, sync, prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle movement, scoring and SERVE/PLAY/OVER game sequencing for a two-player pong.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int STEP_DIV    = 100000,
  parameter int STEP        = 1,
  parameter int Y_INIT      = PONG_Y_INIT,
  parameter int Y_MIN       = PONG_Y_MIN,
  parameter int Y_MAX       = PONG_Y_MAX,
  parameter int DEADBAND    = 10,
  parameter int SERVE_TICKS = 120,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_1_up,
  input  logic       btn_1_dn,
  input  logic       btn_2_up,
  input  logic       btn_2_dn,
  input  logic       btn_start,
  input  logic       cpu_2,
  input  logic [9:0] ball_y,
  input  logic       point_1,
  input  logic       point_2,
  output logic [9:0] bar_1_y,
  output logic [9:0] bar_2_y,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [1:0] winner,
  output logic       freeze
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam logic [9:0]  Y0      = 10'(Y_INIT);
  localparam logic [10:0] YMIN11  = 11'(Y_MIN);
  localparam logic [10:0] YMAX11  = 11'(Y_MAX);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] DB11    = 11'(DEADBAND);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

  logic [4:0] raw_btn, lvl, rse;
  logic       unused_sync;

  assign raw_btn = {btn_start, btn_2_dn, btn_2_up, btn_1_dn, btn_1_up};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    btn_sync u_sync (.clk(clk), .reset(reset), .raw(raw_btn[i]), .level(lvl[i]), .rise(rse[i]));
  end

  // Movement only needs levels, start only needs its edge.
  assign unused_sync = &{1'b0, lvl[4], rse[3:0]};

  function automatic logic [9:0] step_clamp(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] y11, res;
    y11 = {1'b0, y};
    res = y11;
    if (up && !dn)      res = (y11 < YMIN11 + STEP11) ? YMIN11 : y11 - STEP11;
    else if (dn && !up) res = (y11 + STEP11 > YMAX11) ? YMAX11 : y11 + STEP11;
    return res[9:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < WIN) ? s + 4'd1 : s;
  endfunction

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  game_state_t   state, state_nx;
  logic [SW-1:0] serve_cnt, serve_nx;
  logic [9:0]    bar1_nx, bar2_nx;
  logic [3:0]    s1_nx, s2_nx;
  logic [1:0]    win_nx;
  logic          cpu_up, cpu_dn;

  assign cpu_dn = {1'b0, ball_y} > {1'b0, bar_2_y} + DB11;
  assign cpu_up = {1'b0, ball_y} + DB11 < {1'b0, bar_2_y};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SERVE;
      serve_cnt <= '0;
      bar_1_y   <= Y0;
      bar_2_y   <= Y0;
      score_1   <= '0;
      score_2   <= '0;
      winner    <= '0;
    end else begin
      state     <= state_nx;
      serve_cnt <= serve_nx;
      bar_1_y   <= bar1_nx;
      bar_2_y   <= bar2_nx;
      score_1   <= s1_nx;
      score_2   <= s2_nx;
      winner    <= win_nx;
    end
  end

  always_comb begin
    state_nx = state;
    serve_nx = serve_cnt;
    bar1_nx  = bar_1_y;
    bar2_nx  = bar_2_y;
    s1_nx    = score_1;
    s2_nx    = score_2;
    win_nx   = winner;
    case (state)
      ST_SERVE: begin
        if (tick) begin
          if (serve_cnt == SW'(SERVE_TICKS - 1)) begin
            state_nx = ST_PLAY;
            serve_nx = '0;
          end else begin
            serve_nx = serve_cnt + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (point_1 || point_2) begin
          s1_nx = point_1 ? sat_inc(score_1) : score_1;
          s2_nx = point_2 ? sat_inc(score_2) : score_2;
          if (s1_nx == WIN || s2_nx == WIN) begin
            state_nx = ST_OVER;
            win_nx   = {s2_nx == WIN, s1_nx == WIN};
          end else begin
            state_nx = ST_SERVE;
            serve_nx = '0;
            bar1_nx  = Y0;
            bar2_nx  = Y0;
          end
        end else if (tick) begin
          bar1_nx = step_clamp(bar_1_y, lvl[0], lvl[1]);
          bar2_nx = cpu_2 ? step_clamp(bar_2_y, cpu_up, cpu_dn)
                          : step_clamp(bar_2_y, lvl[2], lvl[3]);
        end
      end
      ST_OVER: begin
        if (rse[4]) begin
          state_nx = ST_SERVE;
          serve_nx = '0;
          bar1_nx  = Y0;
          bar2_nx  = Y0;
          s1_nx    = '0;
          s2_nx    = '0;
          win_nx   = '0;
        end
      end
      default: state_nx = ST_SERVE;
    endcase
  end

  assign freeze = (state != ST_PLAY);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: expected snapshots queued by stimulus, checked by a monitor.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_1_up = 0, btn_1_dn = 0, btn_2_up = 0, btn_2_dn = 0, btn_start = 0;
  logic       cpu_2 = 0;
  logic [9:0] ball_y = 10'd0;
  logic       point_1 = 0, point_2 = 0;
  logic [9:0] bar_1_y, bar_2_y;
  logic [3:0] score_1, score_2;
  logic [1:0] winner;
  logic       freeze;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    int b1, b2, s1, s2, w, fr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  paddle_ctrl #(
    .STEP_DIV(4), .SERVE_TICKS(2), .WIN_SCORE(2)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_1_up(btn_1_up), .btn_1_dn(btn_1_dn), .btn_2_up(btn_2_up), .btn_2_dn(btn_2_dn),
    .btn_start(btn_start), .cpu_2(cpu_2), .ball_y(ball_y),
    .point_1(point_1), .point_2(point_2),
    .bar_1_y(bar_1_y), .bar_2_y(bar_2_y), .score_1(score_1), .score_2(score_2),
    .winner(winner), .freeze(freeze)
  );

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int b1, input int b2, input int s1,
                     input int s2, input int w, input int fr);
    exp_t e;
    e.name = nm; e.b1 = b1; e.b2 = b2; e.s1 = s1; e.s2 = s2; e.w = w; e.fr = fr;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares the oldest expectation on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "bar_1_y", int'(bar_1_y), e.b1);
        cmp(e.name, "bar_2_y", int'(bar_2_y), e.b2);
        cmp(e.name, "score_1", int'(score_1), e.s1);
        cmp(e.name, "score_2", int'(score_2), e.s2);
        cmp(e.name, "winner",  int'(winner),  e.w);
        cmp(e.name, "freeze",  int'(freeze),  e.fr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("in_reset", 180, 180, 0, 0, 0, 1);
    cyc(1);
    reset = 1'b1;
    cyc(7);  chk("serve_hold", 180, 180, 0, 0, 0, 1);
    cyc(1);  chk("play_entry", 180, 180, 0, 0, 0, 0);
    btn_1_up = 1;
    cyc(4);  chk("up_tick1", 179, 180, 0, 0, 0, 0);
    cyc(4);  chk("up_tick2", 178, 180, 0, 0, 0, 0);
    btn_start = 1;
    cyc(4);  btn_start = 0;
    cyc(780); chk("up_clamp", 30, 180, 0, 0, 0, 0);
    btn_1_up = 0; btn_1_dn = 1;
    cyc(4);  chk("dn_tick1", 31, 180, 0, 0, 0, 0);
    cyc(1240); chk("dn_clamp", 329, 180, 0, 0, 0, 0);
    btn_1_up = 1;
    cyc(16); chk("both_hold", 329, 180, 0, 0, 0, 0);
    btn_1_up = 0; btn_1_dn = 0;
    cpu_2 = 1; ball_y = 10'd250; btn_2_up = 1;
    cyc(4);  chk("cpu_tick1", 329, 181, 0, 0, 0, 0);
    cyc(336); chk("cpu_reach", 329, 240, 0, 0, 0, 0);
    ball_y = 10'd235;
    cyc(20); chk("cpu_deadband", 329, 240, 0, 0, 0, 0);
    btn_2_up = 0; ball_y = 10'd185; point_2 = 1;
    cyc(1);  point_2 = 0; chk("point_2", 180, 180, 0, 1, 0, 1);
    point_1 = 1;
    cyc(1);  point_1 = 0; chk("serve_ignore_pt", 180, 180, 0, 1, 0, 1);
    cyc(6);  chk("replay", 180, 180, 0, 1, 0, 0);
    cyc(4);  chk("cpu_near_hold", 180, 180, 0, 1, 0, 0);
    point_1 = 1;
    cyc(1);  point_1 = 0; chk("point_1", 180, 180, 1, 1, 0, 1);
    cyc(7);  chk("replay2", 180, 180, 1, 1, 0, 0);
    point_1 = 1; point_2 = 1;
    cyc(1);  point_1 = 0; point_2 = 0; chk("tie_over", 180, 180, 2, 2, 3, 1);
    point_1 = 1;
    cyc(1);  point_1 = 0; chk("over_ignore_pt", 180, 180, 2, 2, 3, 1);
    btn_start = 1;
    cyc(2);  chk("start_sync", 180, 180, 2, 2, 3, 1);
    cyc(1);  chk("restart", 180, 180, 0, 0, 0, 1);
    btn_start = 0;
    cyc(7);  chk("replay3", 180, 180, 0, 0, 0, 0);
    point_1 = 1;
    cyc(1);  point_1 = 0; chk("point_1b", 180, 180, 1, 0, 0, 1);
    cyc(3);
    reset = 1'b0;
    #1;      chk("async_reset", 180, 180, 0, 0, 0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(7);  chk("re_serve_hold", 180, 180, 0, 0, 0, 1);
    cyc(1);  chk("re_play", 180, 180, 0, 0, 0, 0);
    cyc(2);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
